exe_pipe_ctrl: RTL and testbench

//  Sequencing controller for the execute stage. Turns branch/jump resolution into a
//  one-cycle PC redirect plus a timed flush of the fetch/decode/issue pipes. Freezes
//  the pipeline while a multi-cycle op (mul/div) owns the execute slot, with a timeout

---
 rtl/exe_pipe_ctrl_pkg.sv | 22 ++
 rtl/exe_pipe_ctrl_counter.sv | 28 ++
 rtl/exe_pipe_ctrl.sv | 102 ++++++++++
 tb/tb_exe_pipe_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/exe_pipe_ctrl_pkg.sv
// Shared definitions for the execute-stage sequencing controller and the
// decode/execute stages that produce pcselect.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    STALL = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_BR   = 2'b01;
  localparam logic [1:0] PCSEL_JAL  = 2'b10;
  localparam logic [1:0] PCSEL_JALR = 2'b11;

  // Both jump encodings have bit 1 set and always redirect.
  function automatic logic is_redirect(input logic valid, input logic [1:0] pcsel,
                                       input logic taken);
    return valid & (((pcsel == PCSEL_BR) & taken) | pcsel[1]);
  endfunction

endpackage

// File: rtl/exe_pipe_ctrl_counter.sv
// Small load/decrement/increment counter used for the flush length, the
// multi-cycle timeout and the redirect performance count.
module ctrl_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Load has priority over dec, dec over inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - W'(1);
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/exe_pipe_ctrl.sv
// Execute-stage sequencing: one-cycle PC redirect with a timed upstream flush,
// and a pipeline freeze while a multi-cycle op runs, guarded by a timeout.
// Handshake: mc_start_o/mc_kill_o are single-cycle pulses; mc_done_i is a
// single-cycle pulse that only counts while the controller is in STALL.
module exe_pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 3,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [1:0]        pcselect_i,
  input  logic              btaken_i,
  input  logic [XLEN-1:0]   target_i,
  input  logic              mc_req_i,
  input  logic              mc_done_i,
  output logic              pc_load_o,
  output logic [XLEN-1:0]   pc_target_o,
  output logic              flush_o,
  output logic              stall_o,
  output logic              mc_start_o,
  output logic              mc_kill_o,
  output logic              timeout_err_o,
  output logic [CNT_W-1:0]  redirect_cnt_o,
  output ctrl_state_e       dbg_state_o
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TW = $clog2(MC_TIMEOUT);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(MC_TIMEOUT - 1);

  ctrl_state_e state, state_n;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic          err;
  logic          in_run, in_flush, in_stall;
  logic          redirect, redirect_run, start, kill, tmo_hit, flush_last;

  assign in_run       = (state == RUN);
  assign in_flush     = (state == FLUSH);
  assign in_stall     = (state == STALL);
  assign redirect     = is_redirect(valid_i, pcselect_i, btaken_i);
  assign redirect_run = in_run & redirect;
  assign start        = in_run & mc_req_i & ~redirect;
  assign tmo_hit      = (tcnt == TMO_LAST);
  assign kill         = in_stall & ~mc_done_i & tmo_hit;
  assign flush_last   = (fcnt == FW'(1));

  always_comb begin
    state_n = state;
    case (state)
      RUN: begin
        if (redirect)      state_n = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        else if (mc_req_i) state_n = STALL;
      end
      FLUSH:   if (flush_last) state_n = RUN;
      STALL:   if (mc_done_i || tmo_hit) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (kill) err <= 1'b1;
    end
  end

  ctrl_counter #(.W(FW)) u_flush_cnt (
    .clk(clk), .rst(rst), .load(redirect_run), .load_val(FLUSH_INIT),
    .dec(in_flush), .inc(1'b0), .count(fcnt)
  );

  ctrl_counter #(.W(TW)) u_tmo_cnt (
    .clk(clk), .rst(rst), .load(start), .load_val('0),
    .dec(1'b0), .inc(in_stall), .count(tcnt)
  );

  ctrl_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
    .dec(1'b0), .inc(redirect_run), .count(redirect_cnt_o)
  );

  // Outputs are forced low while reset is held, even mid-cycle.
  assign pc_load_o     = ~rst & redirect_run;
  assign pc_target_o   = pc_load_o ? target_i : '0;
  assign flush_o       = ~rst & (redirect_run | in_flush);
  assign stall_o       = ~rst & (start | (in_stall & ~mc_done_i & ~tmo_hit));
  assign mc_start_o    = ~rst & start;
  assign mc_kill_o     = ~rst & kill;
  assign timeout_err_o = err;
  assign dbg_state_o   = state;

endmodule

// File: tb/tb_exe_pipe_ctrl.sv
// Directed and randomized checks of exe_pipe_ctrl against a cycle-level
// reference model of the redirect/flush/stall rules.
module tb_exe_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int FLUSH_CYCLES = 3;
  localparam int MC_TIMEOUT = 64;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_i = 1'b0;
  logic [1:0] pcselect_i = 2'b00;
  logic btaken_i = 1'b0;
  logic [XLEN-1:0] target_i = '0;
  logic mc_req_i = 1'b0;
  logic mc_done_i = 1'b0;
  logic pc_load_o, flush_o, stall_o, mc_start_o, mc_kill_o, timeout_err_o;
  logic [XLEN-1:0] pc_target_o;
  logic [CNT_W-1:0] redirect_cnt_o;
  ctrl_state_e dbg_state_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: flush cycles still owed, stall age, sticky error, count.
  int flush_owed;
  bit stalling;
  int stall_age;
  bit m_err;
  logic [CNT_W-1:0] m_cnt;

  exe_pipe_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES), .MC_TIMEOUT(MC_TIMEOUT),
                  .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pcselect_i(pcselect_i),
    .btaken_i(btaken_i), .target_i(target_i), .mc_req_i(mc_req_i),
    .mc_done_i(mc_done_i), .pc_load_o(pc_load_o), .pc_target_o(pc_target_o),
    .flush_o(flush_o), .stall_o(stall_o), .mc_start_o(mc_start_o),
    .mc_kill_o(mc_kill_o), .timeout_err_o(timeout_err_o),
    .redirect_cnt_o(redirect_cnt_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    flush_owed = 0;
    stalling = 0;
    stall_age = 0;
    m_err = 0;
    m_cnt = '0;
  endtask

  // Apply one cycle of inputs, check all outputs at the negedge, advance model.
  task automatic step(input logic v, input logic [1:0] ps, input logic bt,
                      input logic [31:0] tg, input logic req, input logic done);
    logic e_load, e_flush, e_stall, e_start, e_kill, redir;
    logic [31:0] e_tgt;
    valid_i = v; pcselect_i = ps; btaken_i = bt; target_i = tg;
    mc_req_i = req; mc_done_i = done;
    @(negedge clk);
    e_load = 0; e_flush = 0; e_stall = 0; e_start = 0; e_kill = 0; e_tgt = 0;
    redir = v && ((ps == 2'b01 && bt) || ps == 2'b10 || ps == 2'b11);
    if (flush_owed > 0) begin
      e_flush = 1;
      flush_owed--;
    end else if (stalling) begin
      if (done) begin
        stalling = 0;
      end else if (stall_age == MC_TIMEOUT - 1) begin
        e_kill = 1;
        stalling = 0;
      end else begin
        e_stall = 1;
        stall_age++;
      end
    end else if (redir) begin
      e_load = 1; e_tgt = tg; e_flush = 1;
      flush_owed = FLUSH_CYCLES - 1;
    end else if (req) begin
      e_start = 1; e_stall = 1;
      stalling = 1; stall_age = 0;
    end
    chk("pc_load", 32'(pc_load_o), 32'(e_load));
    chk("pc_target", pc_target_o, e_tgt);
    chk("flush", 32'(flush_o), 32'(e_flush));
    chk("stall", 32'(stall_o), 32'(e_stall));
    chk("mc_start", 32'(mc_start_o), 32'(e_start));
    chk("mc_kill", 32'(mc_kill_o), 32'(e_kill));
    chk("timeout_err", 32'(timeout_err_o), 32'(m_err));
    chk("redirect_cnt", 32'(redirect_cnt_o), 32'(m_cnt));
    if (e_kill) m_err = 1;
    if (e_load) m_cnt = m_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_model();
    repeat (2) @(negedge clk);
    chk("rst_pc_load", 32'(pc_load_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_state", 32'(dbg_state_o), 32'(RUN));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Taken branch: redirect now, flush for three cycles, count 1.
    step(1'b1, 2'b01, 1'b1, 32'h100, 1'b0, 1'b0);
    idle(3);
    chk("cnt_after_br", 32'(redirect_cnt_o), 32'd1);

    // Not-taken branch is no redirect; jalr always redirects.
    step(1'b1, 2'b01, 1'b0, 32'h55, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 32'h2C, 1'b0, 1'b0);
    idle(3);

    // Multi-cycle op finishing after 5 cycles.
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(4);
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1);
    chk("state_after_done", 32'(dbg_state_o), 32'(RUN));

    // Multi-cycle op that never finishes: kill and sticky error.
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(MC_TIMEOUT + 2);
    chk("err_sticky", 32'(timeout_err_o), 32'd1);

    // Async reset mid-stall clears everything between edges.
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_flush", 32'(flush_o), 32'd0);
    chk("arst_err", 32'(timeout_err_o), 32'd0);
    chk("arst_cnt", 32'(redirect_cnt_o), 32'd0);
    chk("arst_state", 32'(dbg_state_o), 32'(RUN));
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    @(posedge clk);
    #1;

    // Redirect and mc_req together: redirect wins; redirect during flush ignored.
    step(1'b1, 2'b01, 1'b1, 32'h200, 1'b1, 1'b0);
    step(1'b1, 2'b10, 1'b0, 32'h300, 1'b0, 1'b0);
    idle(3);
    chk("cnt_one_redirect", 32'(redirect_cnt_o), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end
    // Done pulse outside STALL must be ignored.
    idle(MC_TIMEOUT + 4);
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
